// File: rtl/ov5640_sccb_responder.sv
// SCCB (I2C-like) register-access responder for an OV5640-style target.
// 16-bit register address, 8-bit data, burst auto-increment, open-drain SDA.
module ov5640_sccb_responder #(
  parameter logic [6:0] DEV_ID      = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, ADDR_H, ACK_AH, ADDR_L,
    ACK_AL, WDATA, ACK_WD, RDATA, RACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, scl_hi;
  logic        start, stop;
  logic [6:0]  shift;
  logic [2:0]  bitcnt;
  logic [7:0]  byte_in;
  logic        shifting, last_bit, id_hit;
  logic        rw;
  logic        rd_pend;
  logic [7:0]  rbyte;
  logic [15:0] addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL must be stable high across both samples, so an SCL edge wins
  assign scl_hi   = scl_s & scl_d;
  assign start    = scl_hi & sda_d & ~sda_s;
  assign stop     = scl_hi & ~sda_d & sda_s;

  assign byte_in  = {shift, sda_s};
  assign shifting = (state == DEV) || (state == ADDR_H) ||
                    (state == ADDR_L) || (state == WDATA) ||
                    (state == RDATA);
  assign last_bit = scl_rise & shifting & (bitcnt == 3'd7);
  assign id_hit   = (byte_in[7:1] == DEV_ID);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = DEV;
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = IDLE;
        DEV:     if (last_bit) state_n = id_hit ? ACK_DEV : IGNORE;
        ADDR_H:  if (last_bit) state_n = ACK_AH;
        ADDR_L:  if (last_bit) state_n = ACK_AL;
        WDATA:   if (last_bit) state_n = ACK_WD;
        ACK_DEV: if (scl_fall && sda_oe) state_n = rw ? RDATA : ADDR_H;
        ACK_AH:  if (scl_fall && sda_oe) state_n = ADDR_L;
        ACK_AL:  if (scl_fall && sda_oe) state_n = WDATA;
        ACK_WD:  if (scl_fall && sda_oe) state_n = WDATA;
        RDATA:   if (last_bit) state_n = RACK;
        RACK:    if (scl_rise) state_n = sda_s ? IGNORE : RDATA;
        IGNORE:  state_n = IGNORE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      rd_pend  <= 1'b0;
      rbyte    <= '0;
      addr     <= '0;
      shift    <= '0;
      bitcnt   <= '0;
      rw       <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      rd_pend  <= rd_req;
      if (rd_pend) rbyte <= rd_data;
      if (start || stop) begin
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else begin
        if (scl_rise && shifting) begin
          shift  <= byte_in[6:0];
          bitcnt <= bitcnt + 3'd1;
        end
        if (last_bit) begin
          case (state)
            DEV: begin
              rw <= byte_in[0];
              if (id_hit && byte_in[0]) begin
                rd_req  <= 1'b1;
                rd_addr <= addr;
              end
            end
            ADDR_H: addr[15:8] <= byte_in;
            ADDR_L: addr[7:0]  <= byte_in;
            WDATA: begin
              wr_valid <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= byte_in;
              addr     <= addr + 16'd1;
            end
            default: ;
          endcase
        end
        // initiator ACK on a read byte: prefetch the next register
        if (scl_rise && state == RACK && !sda_s) begin
          addr    <= addr + 16'd1;
          rd_addr <= addr + 16'd1;
          rd_req  <= 1'b1;
          bitcnt  <= '0;
        end
        if (scl_fall) begin
          case (state)
            ACK_DEV: sda_oe <= sda_oe ? (rw & ~rbyte[7]) : 1'b1;
            ACK_AH, ACK_AL, ACK_WD: sda_oe <= ~sda_oe;
            RDATA:   sda_oe <= ~rbyte[3'd7 - bitcnt];
            default: sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_responder.sv
// Directed bench for ov5640_sccb_responder: bit-banged SCCB initiator,
// write-vector table plus read, repeated-start, reset and edge-race cases.
module tb_ov5640_sccb_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        sda_oe, wr_valid, rd_req, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  ov5640_sccb_responder dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // register store: data = low address byte ^ 0x5C, registered on rd_req
  always @(posedge clk) begin
    if (rd_req) rd_data <= rd_addr[7:0] ^ 8'h5C;
  end

  int checks = 0;
  int errors = 0;
  int wn = 0, rn = 0, oe_cyc = 0, busy_cyc = 0;
  logic [15:0] wa [64];
  logic [7:0]  wd [64];
  logic [15:0] ra [64];

  always @(negedge clk) begin
    if (wr_valid && wn < 64) begin
      wa[wn] = wr_addr;
      wd[wn] = wr_data;
      wn = wn + 1;
    end
    if (rd_req && rn < 64) begin
      ra[rn] = rd_addr;
      rn = rn + 1;
    end
    if (sda_oe) oe_cyc = oe_cyc + 1;
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(negedge clk);
  endtask

  task automatic start_c();
    if (!scl) begin
      sda_m = 1'b1; q();
      scl = 1'b1; q(); q();
    end
    sda_m = 1'b0; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q();
    scl = 1'b1; q(); q();
    sda_m = 1'b1; q(); q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; q();
      scl = 1'b1; q(); q();
      scl = 1'b0; q();
    end
  endtask

  task automatic ack_clk(output logic ack);
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    ack = ~sda_line; q();
    scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    ack_clk(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; q();
      scl = 1'b1; q();
      b[i] = sda_line; q();
      scl = 1'b0; q();
    end
    sda_m = ~mack; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  typedef struct {
    logic [0:4][7:0] b;
    int              n;
    int              acks;
    int              nwr;
    logic [15:0]     a0;
    logic [7:0]      d0;
    logic [15:0]     a1;
    logic [7:0]      d1;
  } vec_t;

  vec_t vec [6];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       a;
    int         acks, w0, r0, o0, b0;
    logic [7:0] rb;

    vec[0] = '{b: {8'h78, 8'h30, 8'h08, 8'h82, 8'h00}, n: 4, acks: 4,
               nwr: 1, a0: 16'h3008, d0: 8'h82, a1: 16'h0, d1: 8'h0};
    vec[1] = '{b: {8'h42, 8'h30, 8'h08, 8'h82, 8'h00}, n: 4, acks: 0,
               nwr: 0, a0: 16'h0, d0: 8'h0, a1: 16'h0, d1: 8'h0};
    vec[2] = '{b: {8'h78, 8'h58, 8'h00, 8'h23, 8'h14}, n: 5, acks: 5,
               nwr: 2, a0: 16'h5800, d0: 8'h23, a1: 16'h5801, d1: 8'h14};
    vec[3] = '{b: {8'h78, 8'hFF, 8'hFF, 8'hAA, 8'h55}, n: 5, acks: 5,
               nwr: 2, a0: 16'hFFFF, d0: 8'hAA, a1: 16'h0000, d1: 8'h55};
    vec[4] = '{b: {8'h78, 8'h12, 8'h34, 8'h00, 8'h00}, n: 3, acks: 3,
               nwr: 0, a0: 16'h0, d0: 8'h0, a1: 16'h0, d1: 8'h0};
    vec[5] = '{b: {8'h7A, 8'h30, 8'h00, 8'h00, 8'h00}, n: 2, acks: 0,
               nwr: 0, a0: 16'h0, d0: 8'h0, a1: 16'h0, d1: 8'h0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst wr_valid", wr_valid, 0);
    chk("rst rd_req", rd_req, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst rd_addr", rd_addr, 0);
    q();

    for (int v = 0; v < 6; v++) begin
      w0 = wn; o0 = oe_cyc; acks = 0;
      start_c();
      for (int k = 0; k < vec[v].n; k++) begin
        send_byte(vec[v].b[k], a);
        acks += int'(a);
      end
      chk($sformatf("v%0d busy", v), busy, 1);
      stop_c();
      chk($sformatf("v%0d idle", v), busy, 0);
      chk($sformatf("v%0d acks", v), acks, vec[v].acks);
      chk($sformatf("v%0d nwr", v), wn - w0, vec[v].nwr);
      chk($sformatf("v%0d oe", v), oe_cyc != o0, vec[v].acks > 0);
      if (vec[v].nwr >= 1) begin
        chk($sformatf("v%0d a0", v), wa[w0], vec[v].a0);
        chk($sformatf("v%0d d0", v), wd[w0], vec[v].d0);
      end
      if (vec[v].nwr >= 2) begin
        chk($sformatf("v%0d a1", v), wa[w0+1], vec[v].a1);
        chk($sformatf("v%0d d1", v), wd[w0+1], vec[v].d1);
      end
      q(); q();
    end

    // two-phase write then read burst
    w0 = wn;
    start_c();
    send_byte(8'h78, a); send_byte(8'h30, a); send_byte(8'h0A, a);
    stop_c();
    q();
    r0 = rn;
    start_c();
    send_byte(8'h79, a);
    chk("rd id ack", a, 1);
    read_byte(1'b1, rb);
    chk("rd byte0", rb, 8'h56);
    read_byte(1'b0, rb);
    chk("rd byte1", rb, 8'h57);
    chk("rd oe released", sda_oe, 0);
    stop_c();
    chk("rd nreq", rn - r0, 2);
    chk("rd addr0", ra[r0], 16'h300A);
    chk("rd addr1", ra[r0+1], 16'h300B);
    chk("rd nwr", wn - w0, 0);
    chk("rd idle", busy, 0);
    q();

    // repeated start inside ADDR_L
    w0 = wn;
    start_c();
    send_byte(8'h78, a); send_byte(8'h30, a);
    send_bits(8'h08, 5);
    start_c();
    send_byte(8'h78, a);
    chk("rs id ack", a, 1);
    stop_c();
    chk("rs nwr", wn - w0, 0);
    q();

    // reset during ACK_AH
    w0 = wn;
    start_c();
    send_byte(8'h78, a);
    send_bits(8'h30, 8);
    q();
    chk("rst ack drive", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst ack oe", sda_oe, 0);
    chk("rst ack busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    ack_clk(a);
    send_byte(8'h08, a); acks += int'(a);
    send_byte(8'h82, a); acks += int'(a);
    stop_c();
    chk("post-rst acks", acks, 0);
    chk("post-rst nwr", wn - w0, 0);
    q();
    start_c();
    send_byte(8'h78, a); send_byte(8'hAB, a);
    send_byte(8'hCD, a); send_byte(8'hEF, a);
    stop_c();
    chk("recover nwr", wn - w0, 1);
    chk("recover addr", wa[w0], 16'hABCD);
    q();

    // SDA toggling with SCL rising: never START/STOP
    b0 = busy_cyc;
    scl = 1'b0; q();
    for (int i = 0; i < 6; i++) begin
      scl = 1'b1; sda_m = ~sda_m; q(); q();
      scl = 1'b0; q(); q();
    end
    sda_m = 1'b1; q();
    scl = 1'b1; q(); q();
    chk("race idle", busy_cyc - b0, 0);
    w0 = wn;
    start_c();
    send_byte(8'h78, a);
    for (int i = 0; i < 4; i++) begin
      scl = 1'b1; sda_m = ~sda_m; q(); q();
      scl = 1'b0; q(); q();
    end
    chk("race busy", busy, 1);
    stop_c();
    chk("race idle2", busy, 0);
    chk("race nwr", wn - w0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov5640_sccb_responder.md
OV5640_SCCB_RESPONDER -- requirements
Module: ov5640_sccb_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h3C, meaning the 7-bit SCCB slave ID (write byte 0x78, read byte 0x79).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on SCL and SDA (minimum 2).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; every flop is on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 scl_i  input  1  SCCB clock from the initiator, asynchronous to clk.
REQ-007 sda_i  input  1  SCCB data line as sensed, asynchronous to clk.
REQ-008 sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain).
REQ-009 wr_valid  output  1  one-cycle pulse; a register write has been received.
REQ-010 wr_addr  output  16  register address, valid with wr_valid.
REQ-011 wr_data  output  8  register data, valid with wr_valid.
REQ-012 rd_req  output  1  one-cycle read request to the external register store.
REQ-013 rd_addr  output  16  address for rd_req.
REQ-014 rd_data  input  8  read data, registered by the store; valid the cycle after rd_req.
REQ-015 busy  output  1  high from START until STOP.

Function
REQ-016 SHALL synchronize scl_i and sda_i through SYNC_STAGES flops, then detect edges against one further delayed copy.
REQ-017 SHALL support clk >= 16x the SCL frequency.
REQ-018 START is synced SDA falling while synced SCL is high; STOP is synced SDA rising while synced SCL is high.
REQ-019 SHALL sample SDA on each synced SCL rising edge, MSB first, using a 3-bit bit counter.
REQ-020 SHALL change sda_oe only in the cycle after a synced SCL falling edge.
REQ-021 FSM states: IDLE, DEV, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL, WDATA, ACK_WD, RDATA, RACK, IGNORE.
REQ-022 IDLE->DEV on START.
REQ-023 DEV, after 8 bits: if ID matches with R/W=0 -> ACK_DEV (write path); if ID matches with R/W=1 -> ACK_DEV (read path); on mismatch -> IGNORE with no ACK.
REQ-024 ACK_DEV, ACK_AH, ACK_AL, ACK_WD: drive sda_oe=1 from the falling edge after the 8th bit to the next falling edge, then release.
REQ-025 Write path sequence: ADDR_H -> ACK_AH -> ADDR_L -> ACK_AL -> WDATA -> ACK_WD -> WDATA ...
REQ-026 wr_valid SHALL pulse the cycle after the 8th WDATA rising edge is detected, with wr_addr = current address.
REQ-027 SHALL increment the internal address by 1 after each data byte (multi-byte burst); 16'hFFFF wraps to 16'h0000.
REQ-028 A STOP after ACK_AL (2-phase write) SHALL keep the latched address for a following read.
REQ-029 Read path: rd_req SHALL pulse in the cycle the 8th DEV bit is detected, with rd_addr = latched address; rd_data SHALL be captured one cycle later.
REQ-030 RDATA: drive the captured byte MSB first, sda_oe = ~bit, updated after each falling edge, starting at the falling edge that ends ACK_DEV.
REQ-031 RACK: sda_oe=0; the initiator ACK (SDA low) -> increment address, pulse rd_req, return to RDATA; NACK -> IGNORE.
REQ-032 START in any state (repeated start) -> DEV, with bit counter cleared and sda_oe=0 at once.
REQ-033 STOP in any state -> IDLE with sda_oe=0; a partial byte is discarded and produces no wr_valid.
REQ-034 IGNORE SHALL hold sda_oe=0 and leave it only on START or STOP.
REQ-035 Simultaneous SCL and SDA edges in the same cycle: the SCL edge takes priority, and no START/STOP is declared.

Reset
REQ-036 On reset: state=IDLE, sda_oe=0, wr_valid=0, rd_req=0, busy=0, wr_addr=0, wr_data=0, rd_addr=0, internal address=0, bit counter=0.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no write pulse; after reset release the block waits for a fresh START.

Verification
REQ-038 Write 0x78, 0x30, 0x08, 0x82, STOP -> 4 ACKs; exactly one wr_valid with wr_addr=0x3008, wr_data=0x82.
REQ-039 Write 0x42, ... -> no ACK (sda_oe stays 0), no wr_valid, busy clears on STOP.
REQ-040 Write 0x78, 0x30, 0x0A, STOP; then START, 0x79 with rd_data=0x56 -> rd_req with rd_addr=0x300A; SDA shows 0,1,0,1,0,1,1,0; NACK -> release, IDLE on STOP.
REQ-041 Burst 0x78, 0x58, 0x00, 0x23, 0x14 -> wr_valid (0x5800, 0x23) then (0x5801, 0x14); burst at 0xFFFF -> second write goes to 0x0000.
REQ-042 Repeated START after 5 bits of ADDR_L -> no wr_valid, new ID accepted; reset during ACK_AH -> sda_oe=0 the next cycle.
REQ-043 SCL at clk/16 with SDA toggling in the same cycle as SCL rising -> no false START/STOP.
